// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and line constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: standard-read FIFO pop port between the TX FIFO and the transmitter
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic rd_en;
  logic empty;
  logic [DATA_WIDTH-1:0] dout;
  modport master (output rd_en, input empty, dout);
  modport slave (input rd_en, output empty, dout);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider, restartable, pulses bit_done at the last cycle of each period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_done = cnt_q == CW'(CLKS_PER_BIT - 1);
  // wrap on period end so consecutive bits in one state never drift
  always_comb cnt_d = (restart || bit_done) ? '0 : cnt_q + CW'(1);
  // divider count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: pops words from a standard-read FIFO and serialises them as start/data/parity/stop frames
module uart_tx import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  uart_tx_if.master  fifo,
  output logic       txd,
  output logic       busy
);
  localparam int IW = 4;
  tx_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_q, par_d, txd_q, txd_d, busy_q, busy_d, bit_done;
  assign fifo.rd_en = (state_q == IDLE) & tx_en & ~fifo.empty;
  assign txd = txd_q;
  assign busy = busy_q;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .restart(state_d != state_q),
    .bit_done(bit_done)
  );
  // next-state, shifter and registered line/busy values
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d = par_q;
    idx_d = idx_q;
    txd_d = txd_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (fifo.rd_en) begin
        state_d = LOAD;
        busy_d = 1'b1;
      end
      LOAD: begin
        shift_d = fifo.dout;
        par_d = (PARITY == PAR_ODD) ? ~^fifo.dout : ^fifo.dout;
        txd_d = 1'b0;
        state_d = START;
      end
      START: if (bit_done) begin
        state_d = DATA;
        txd_d = shift_q[0];
        idx_d = '0;
      end
      DATA: if (bit_done) begin
        if (idx_q == IW'(DATA_WIDTH - 1)) begin
          state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          txd_d = (PARITY != PAR_NONE) ? par_q : LINE_IDLE;
          idx_d = '0;
        end else begin
          shift_d = shift_q >> 1;
          txd_d = shift_q[1];
          idx_d = idx_q + IW'(1);
        end
      end
      uart_pkg::PARITY: if (bit_done) begin
        state_d = STOP;
        txd_d = LINE_IDLE;
        idx_d = '0;
      end
      STOP: if (bit_done) begin
        if (idx_q == IW'(STOP_BITS - 1)) begin
          state_d = IDLE;
          busy_d = 1'b0;
        end else idx_d = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drives the line idle immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q <= 1'b0;
      idx_q <= '0;
      txd_q <= LINE_IDLE;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q <= par_d;
      idx_q <= idx_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scoreboard bench for uart_tx at 4 clocks per bit
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n, tx_en0, arm, emp_tog, rst_seen;
  logic txd0, busy0, txd1, busy1, txd2, busy2;
  logic pop1 = 1'b0;
  logic pop2 = 1'b0;
  logic [7:0] mem [16];
  logic [7:0] exp0 [$];
  int wp = 0;
  int rp = 0;
  int pops0 = 0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  uart_tx_if #(.DATA_WIDTH(8)) f0 ();
  uart_tx_if #(.DATA_WIDTH(8)) f1 ();
  uart_tx_if #(.DATA_WIDTH(8)) f2 ();
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .fifo(f0), .txd(txd0), .busy(busy0));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(1'b1), .fifo(f1), .txd(txd1), .busy(busy1));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(1'b1), .fifo(f2), .txd(txd2), .busy(busy2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign f0.empty = (wp == rp) | emp_tog;
  always @(posedge clk)
    if (f0.rd_en) begin
      f0.dout <= mem[rp % 16];
      rp <= rp + 1;
      pops0 <= pops0 + 1;
    end
  assign f1.dout = 8'h07;
  assign f2.dout = 8'h07;
  assign f1.empty = ~arm | pop1;
  assign f2.empty = ~arm | pop2;
  always @(posedge clk) begin
    if (f1.rd_en) pop1 <= 1'b1;
    if (f2.rd_en) pop2 <= 1'b1;
  end
  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] w);
    mem[wp % 16] = w;
    wp++;
    exp0.push_back(w);
  endtask

  function automatic logic sig(input int w);
    return (w == 0) ? txd0 : (w == 1) ? busy0 : (w == 2) ? f0.rd_en : txd1;
  endfunction

  task automatic wait_for(input int w, input logic val, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sig(w) === val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // scoreboard monitor: decode each dut0 frame mid-bit and compare with the oldest pushed word
  initial begin
    logic [7:0] w, e;
    logic st, sp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd0 === 1'b0) begin
        rst_seen = 1'b0;
        repeat (2) @(negedge clk);
        st = txd0;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          w[i] = txd0;
        end
        repeat (4) @(negedge clk);
        sp = txd0;
        if (!rst_seen) begin
          if (exp0.size() == 0) chk("frame_unexpected", {22'd0, sp, w, st}, 32'hFFFF_FFFF);
          else begin
            e = exp0.pop_front();
            chk("frame0", {22'd0, sp, w, st}, {22'd0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] d1, d2;
    rst_n = 1'b0;
    tx_en0 = 1'b0;
    arm = 1'b0;
    emp_tog = 1'b0;
    rst_seen = 1'b0;
    repeat (3) tick();
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_rd_en", 32'(f0.rd_en), 32'd0);
    chk("rst_txd1", 32'(txd1), 32'd1);
    rst_n = 1'b1;
    push0(8'h55);
    repeat (10) tick();
    chk("dis_pops", 32'(pops0), 32'd0);
    chk("dis_rd_en", 32'(f0.rd_en), 32'd0);
    chk("dis_txd", 32'(txd0), 32'd1);
    chk("dis_busy", 32'(busy0), 32'd0);
    tx_en0 = 1'b1;
    #1;
    chk("pop_now", 32'(f0.rd_en), 32'd1);
    c0 = cyc;
    tick();
    chk("pop_single", 32'(f0.rd_en), 32'd0);
    chk("busy_rise", 32'(busy0), 32'd1);
    chk("load_txd", 32'(txd0), 32'd1);
    tick();
    chk("start_lat", 32'(txd0), 32'd0);
    chk("start_cyc", 32'(cyc - c0), 32'd2);
    wait_for(1, 1'b0, 100, "wait_busy_fall");
    chk("busy_len", 32'(cyc - c0), 32'd42);
    chk("pops_1", 32'(pops0), 32'd1);
    push0(8'hA3);
    push0(8'h0F);
    wait_for(1, 1'b1, 5, "b2b_busy");
    wait_for(1, 1'b0, 100, "b2b_end1");
    c0 = cyc;
    wait_for(0, 1'b0, 10, "b2b_start2");
    chk("b2b_gap", 32'(cyc - c0), 32'd2);
    wait_for(1, 1'b0, 100, "b2b_end2");
    chk("pops_3", 32'(pops0), 32'd3);
    push0(8'h5A);
    push0(8'h81);
    wait_for(0, 1'b0, 10, "txen_start");
    repeat (17) tick();
    tx_en0 = 1'b0;
    wait_for(1, 1'b0, 100, "txen_end");
    repeat (10) tick();
    chk("txen_pops", 32'(pops0), 32'd4);
    chk("txen_busy", 32'(busy0), 32'd0);
    chk("txen_txd", 32'(txd0), 32'd1);
    push0(8'h99);
    tx_en0 = 1'b1;
    wait_for(0, 1'b0, 10, "tog_start");
    repeat (6) tick();
    c0 = pops0;
    for (int i = 0; i < 20; i++) begin
      emp_tog = ~emp_tog;
      tick();
    end
    emp_tog = 1'b0;
    chk("tog_pops", 32'(pops0 - c0), 32'd0);
    wait_for(1, 1'b0, 100, "tog_end1");
    wait_for(1, 1'b1, 5, "tog_next");
    wait_for(1, 1'b0, 100, "tog_end2");
    chk("pops_6", 32'(pops0), 32'd6);
    push0(8'hE7);
    wait_for(0, 1'b0, 10, "rst_start");
    repeat (21) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_txd", 32'(txd0), 32'd1);
    chk("arst_busy", 32'(busy0), 32'd0);
    exp0.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("post_rst_idle", 32'(txd0), 32'd1);
    push0(8'h3C);
    wait_for(1, 1'b1, 5, "post_rst_busy");
    wait_for(1, 1'b0, 100, "post_rst_end");
    chk("pops_8", 32'(pops0), 32'd8);
    arm = 1'b1;
    wait_for(3, 1'b0, 10, "par_start");
    chk("par_sync", 32'(txd2), 32'd0);
    repeat (6) tick();
    for (int i = 0; i < 8; i++) begin
      d1[i] = txd1;
      d2[i] = txd2;
      repeat (4) tick();
    end
    chk("even_data", 32'(d1), 32'h07);
    chk("odd_data", 32'(d2), 32'h07);
    chk("even_par", 32'(txd1), 32'd1);
    chk("odd_par", 32'(txd2), 32'd0);
    repeat (4) tick();
    chk("stop1_txd1", 32'(txd1), 32'd1);
    chk("stop1_txd2", 32'(txd2), 32'd1);
    tick();
    chk("odd_busy_hold", 32'(busy2), 32'd1);
    tick();
    chk("odd_busy_fall", 32'(busy2), 32'd0);
    chk("two_stop_busy", 32'(busy1), 32'd1);
    repeat (3) tick();
    chk("two_stop_txd", 32'(txd1), 32'd1);
    chk("two_stop_hold", 32'(busy1), 32'd1);
    tick();
    chk("two_stop_fall", 32'(busy1), 32'd0);
    repeat (5) tick();
    chk("sb_drained", 32'(exp0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
